// File: rtl/branch_predict_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_unit_if
// Description : Fetch-lookup and execute-resolve signal bundle for the
//               branch prediction unit.
// Revision    : 1.0
// ============================================================================
interface branch_predict_unit_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] fetch_pc;
    logic              pred_taken;
    logic [DATA_W-1:0] pred_target;

    logic              resolve_valid;
    logic [DATA_W-1:0] resolve_pc;
    logic [DATA_W-1:0] resolve_updated_pc;
    logic [DATA_W-1:0] resolve_instruction;
    logic [DATA_W-1:0] resolve_offset;
    logic              resolve_is_jump;
    logic              resolve_taken;
    logic              resolve_pred_taken;
    logic [DATA_W-1:0] resolve_pred_target;
    logic              btb_flush;

    logic [DATA_W-1:0] branch_pc;
    logic [DATA_W-1:0] jump_pc;
    logic              mispredict;
    logic [DATA_W-1:0] redirect_pc;

    modport master (
        output fetch_pc, resolve_valid, resolve_pc, resolve_updated_pc,
               resolve_instruction, resolve_offset, resolve_is_jump,
               resolve_taken, resolve_pred_taken, resolve_pred_target,
               btb_flush,
        input  pred_taken, pred_target, branch_pc, jump_pc, mispredict,
               redirect_pc
    );

    modport slave (
        input  fetch_pc, resolve_valid, resolve_pc, resolve_updated_pc,
               resolve_instruction, resolve_offset, resolve_is_jump,
               resolve_taken, resolve_pred_taken, resolve_pred_target,
               btb_flush,
        output pred_taken, pred_target, branch_pc, jump_pc, mispredict,
               redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_unit
// Description : Next-PC prediction with a direct-mapped BTB and saturating
//               direction counters, plus resolve-time target/mispredict logic.
// Revision    : 1.0
// ============================================================================
module branch_predict_unit #(
    parameter int DATA_W    = 32,
    parameter int BTB_DEPTH = 16,
    parameter int CNT_W     = 2
) (
    input wire clk,
    input wire arst_n,
    branch_predict_unit_if.slave bus
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = DATA_W - IDX_W - 2;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_wt  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] c_cnt_wnt = c_cnt_wt - CNT_W'(1);

    logic              w_valid  [BTB_DEPTH];
    logic [TAG_W-1:0]  w_tag    [BTB_DEPTH];
    logic [DATA_W-1:0] w_target [BTB_DEPTH];
    logic [CNT_W-1:0]  w_cnt    [BTB_DEPTH];

    logic [IDX_W-1:0]  w_fetch_idx;
    logic [TAG_W-1:0]  w_fetch_tag;
    logic              w_fetch_hit;
    logic              w_pred_taken;

    logic [IDX_W-1:0]  w_res_idx;
    logic [TAG_W-1:0]  w_res_tag;
    logic              w_res_hit;
    logic [DATA_W-1:0] w_branch_pc;
    logic [DATA_W-1:0] w_jump_pc;
    logic              w_taken_eff;
    logic [DATA_W-1:0] w_actual;

    logic              w_wr_en;
    logic [DATA_W-1:0] w_wr_target;
    logic [CNT_W-1:0]  w_wr_cnt;
    logic              w_unused;

    // ---------------- Fetch-side lookup ----------------
    assign w_fetch_idx  = bus.fetch_pc[IDX_W+1:2];
    assign w_fetch_tag  = bus.fetch_pc[DATA_W-1:IDX_W+2];
    assign w_fetch_hit  = w_valid[w_fetch_idx] && (w_tag[w_fetch_idx] == w_fetch_tag);
    assign w_pred_taken = w_fetch_hit && w_cnt[w_fetch_idx][CNT_W-1];

    assign bus.pred_taken  = w_pred_taken;
    assign bus.pred_target = w_pred_taken ? w_target[w_fetch_idx]
                                          : bus.fetch_pc + DATA_W'(4);

    // ---------------- Resolve-side target and mispredict ----------------
    assign w_branch_pc = (bus.resolve_offset << 2) + bus.resolve_updated_pc;
    assign w_jump_pc   = {bus.resolve_updated_pc[DATA_W-1:28],
                          bus.resolve_instruction[25:0], 2'b00};
    assign w_taken_eff = bus.resolve_is_jump || bus.resolve_taken;
    assign w_actual    = bus.resolve_is_jump ? w_jump_pc : w_branch_pc;

    assign bus.branch_pc   = w_branch_pc;
    assign bus.jump_pc     = w_jump_pc;
    assign bus.mispredict  = bus.resolve_valid &&
                             ((w_taken_eff != bus.resolve_pred_taken) ||
                              (w_taken_eff && (bus.resolve_pred_target != w_actual)));
    assign bus.redirect_pc = (bus.resolve_valid && w_taken_eff) ? w_actual
                                                                : bus.resolve_updated_pc;

    assign w_res_idx = bus.resolve_pc[IDX_W+1:2];
    assign w_res_tag = bus.resolve_pc[DATA_W-1:IDX_W+2];
    assign w_res_hit = w_valid[w_res_idx] && (w_tag[w_res_idx] == w_res_tag);

    // Training decision: one entry at most, selected by the resolved PC.
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_target = w_target[w_res_idx];
        w_wr_cnt    = w_cnt[w_res_idx];
        if (bus.resolve_valid && !bus.btb_flush) begin
            if (w_res_hit) begin
                w_wr_en = 1'b1;
                if (bus.resolve_is_jump) begin
                    w_wr_cnt    = c_cnt_max;
                    w_wr_target = w_actual;
                end else if (bus.resolve_taken) begin
                    w_wr_cnt    = (w_cnt[w_res_idx] == c_cnt_max) ? c_cnt_max
                                                                  : w_cnt[w_res_idx] + CNT_W'(1);
                    w_wr_target = w_actual;
                end else begin
                    w_wr_cnt    = (w_cnt[w_res_idx] == '0) ? '0
                                                           : w_cnt[w_res_idx] - CNT_W'(1);
                end
            end else if (w_taken_eff) begin
                w_wr_en     = 1'b1;
                w_wr_cnt    = bus.resolve_is_jump ? c_cnt_max : c_cnt_wt;
                w_wr_target = w_actual;
            end
        end
    end

    // ---------------- BTB storage ----------------
    for (genvar i = 0; i < BTB_DEPTH; i++) begin : g_entry
        logic              valid_d,  valid_q;
        logic [TAG_W-1:0]  tag_d,    tag_q;
        logic [DATA_W-1:0] target_d, target_q;
        logic [CNT_W-1:0]  cnt_d,    cnt_q;

        always_comb begin
            valid_d  = valid_q;
            tag_d    = tag_q;
            target_d = target_q;
            cnt_d    = cnt_q;
            if (bus.btb_flush) begin
                valid_d = 1'b0;
            end else if (w_wr_en && (w_res_idx == IDX_W'(i))) begin
                valid_d  = 1'b1;
                tag_d    = w_res_tag;
                target_d = w_wr_target;
                cnt_d    = w_wr_cnt;
            end
        end

        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                valid_q  <= 1'b0;
                tag_q    <= '0;
                target_q <= '0;
                cnt_q    <= c_cnt_wnt;
            end else begin
                valid_q  <= valid_d;
                tag_q    <= tag_d;
                target_q <= target_d;
                cnt_q    <= cnt_d;
            end
        end

        assign w_valid[i]  = valid_q;
        assign w_tag[i]    = tag_q;
        assign w_target[i] = target_q;
        assign w_cnt[i]    = cnt_q;
    end

    // Word-alignment bits and the jump opcode field carry no prediction state.
    assign w_unused = ^{bus.fetch_pc[1:0], bus.resolve_pc[1:0],
                        bus.resolve_instruction[DATA_W-1:26]};

endmodule
`default_nettype wire

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised next-PC block for the fetch/execute loop: combinational branch/jump target computation plus a direct-mapped branch target buffer (BTB) with saturating 2-bit direction counters. Fetch gets a predicted next PC in the same cycle. Execute reports resolved branches and jumps; the block computes the actual target, flags a mispredict with a redirect PC, and trains the BTB on the next clock edge.

## Interface
- DATA_W, 32, datapath width; must be at least 32, since jump targets use bits [31:28].
- BTB_DEPTH, 16, number of BTB entries; power of two, at least 2. IDX_W = log2(BTB_DEPTH).
- CNT_W, 2, direction counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- arst_n  in  1  reset, asynchronous, active-low.
- fetch_pc  in  DATA_W  PC of the instruction in fetch.
- pred_taken  out  1  BTB hit and counter MSB set.
- pred_target  out  DATA_W  stored target if pred_taken, else fetch_pc+4.
- resolve_valid  in  1  one resolved control-flow instruction this cycle.
- resolve_pc  in  DATA_W  PC of the resolved instruction.
- resolve_updated_pc  in  DATA_W  resolve_pc+4.
- resolve_instruction  in  DATA_W  raw instruction word (jump index in [25:0]).
- resolve_offset  in  DATA_W  sign-extended branch offset, in words.
- resolve_is_jump  in  1  unconditional jump.
- resolve_taken  in  1  branch condition outcome; ignored when resolve_is_jump=1.
- resolve_pred_taken  in  1  pred_taken carried down the pipe for this instruction.
- resolve_pred_target  in  DATA_W  pred_target carried down the pipe.
- btb_flush  in  1  synchronous invalidate of all entries.
- branch_pc  out  DATA_W  (resolve_offset<<2) + resolve_updated_pc, modulo 2^DATA_W.
- jump_pc  out  DATA_W  {resolve_updated_pc[DATA_W-1:28], (resolve_instruction<<2)[27:0]}.
- mispredict  out  1  resolved path differs from predicted path.
- redirect_pc  out  DATA_W  correct next PC when mispredict=1.

## Operation
BTB addressing:
- index = pc[IDX_W+1:2]; tag = pc[DATA_W-1:IDX_W+2].
- Each entry holds valid, tag, target[DATA_W], cnt[CNT_W].
- Lookup: hit = valid[idx] && tag[idx]==fetch_tag.
- pred_taken = hit && cnt[idx][CNT_W-1].

Resolve, combinational, qualified by resolve_valid:
- taken_eff = resolve_is_jump || resolve_taken.
- actual = resolve_is_jump ? jump_pc : branch_pc.
- mispredict = resolve_valid && (taken_eff != resolve_pred_taken || (taken_eff && resolve_pred_target != actual)).
- redirect_pc = taken_eff ? actual : resolve_updated_pc.
- When resolve_valid=0: mispredict=0 and redirect_pc=resolve_updated_pc.

Update, at the edge where resolve_valid=1 and btb_flush=0:
- Hit, jump: cnt set to max; target set to actual.
- Hit, branch taken: cnt += 1, saturating at max; target set to actual.
- Hit, branch not taken: cnt -= 1, saturating at 0; target unchanged.
- Miss, taken_eff=1: allocate by overwriting the entry. Set valid=1, write tag and target=actual. cnt = max for a jump, or the weakly-taken value (MSB set, other bits 0, 2'b10 at CNT_W=2) for a branch.
- Miss, not taken: no change.

Flush and reset:
- btb_flush=1 clears every valid bit at the edge and suppresses the update in that cycle.
- Reset clears all valid bits, cnt to weakly not-taken (2'b01 at CNT_W=2), and target to 0.

## Timing
- Lookup is combinational from fetch_pc and registered state, with zero latency.
- Resolve outputs (branch_pc, jump_pc, mispredict, redirect_pc) are combinational from the resolve inputs.
- A BTB update is visible to lookup from the cycle after the training edge. A same-cycle lookup of the entry being written sees the old contents; there is no bypass.
- During and after reset, until the first update: pred_taken=0 and pred_target=fetch_pc+4. Other outputs follow their inputs.
- Reset asserted mid-operation clears the state immediately and asynchronously. Any pending update is lost.
- Exactly one update per cycle. Index aliasing between different PCs is resolved by the tag compare only; the last writer wins.

## Test plan
- Reset, then fetch_pc=0x0040_0010 -> pred_taken=0, pred_target=0x0040_0014.
- Branch training (resolve_pc=0x0040_0010, updated 0x0040_0014, offset=0x0000_0004, taken, pred_taken=0): mispredict=1, redirect_pc=0x0040_0024. Next cycle fetch_pc=0x0040_0010 -> pred_taken=1, pred_target=0x0040_0024.
- Counter saturation, on the same branch: resolve taken three times, then not-taken once -> still predicted taken. Then not-taken twice more -> pred_taken=0; the entry stays valid.
- Jump: resolve_instruction=0x0810_0000, updated_pc=0x0040_0008, is_jump=1 -> jump_pc=0x0040_0000, mispredict=1. Next lookup of 0x0040_0004 -> pred_taken=1, pred_target=0x0040_0000.
- Alias: PCs 0x0040_0010 and 0x0040_0050 with BTB_DEPTH=16 share index 4 but differ in tag. Train the first, look up the second -> miss. Train the second as taken -> the first now misses.
- Flush and mid-run reset: btb_flush=1 together with resolve_valid=1 -> no entry written, all lookups miss. Assert arst_n=0 between clock edges -> pred_taken drops to 0 immediately.
